// File: rtl/mark_score_ctrl_if.sv
// Purpose: pixel/score/ROM signal bundle between the score-tally controller and its surroundings.
// Latency: none (wires only).
// Backpressure: none; all signals are free-running video-rate strobes and levels.
// Ports: pixel position/video_on, frame_tick, point/clear pulses, sprite ROM address/data,
//        mark pixel output, live counts and game_over.
interface mark_score_ctrl_if;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        frame_tick;
    logic        p1_point;
    logic        p2_point;
    logic        clear_scores;
    logic [4:0]  rom_row;
    logic [1:0]  rom_col;
    logic [11:0] rom_data;
    logic        mark_on;
    logic [11:0] mark_rgb;
    logic [3:0]  p1_count;
    logic [3:0]  p2_count;
    logic        game_over;

    // Environment side: drives pixels, pulses and the ROM data.
    modport master (
        output pixel_x, pixel_y, video_on, frame_tick,
        output p1_point, p2_point, clear_scores, rom_data,
        input  rom_row, rom_col, mark_on, mark_rgb,
        input  p1_count, p2_count, game_over
    );

    // Controller side.
    modport slave (
        input  pixel_x, pixel_y, video_on, frame_tick,
        input  p1_point, p2_point, clear_scores, rom_data,
        output rom_row, rom_col, mark_on, mark_rgb,
        output p1_count, p2_count, game_over
    );
endinterface

// File: rtl/mark_score_ctrl.sv
// Purpose: two-player score tally sharing one mark sprite ROM; per-frame display copies, slot decode, keyed pixel out.
// Latency: 1 clock from pixel_x/pixel_y to mark_on/mark_rgb (matches the registered sprite ROM).
// Backpressure: none; pixel stream and point pulses are accepted every cycle.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries pixel position, pulses,
//        ROM row/col/data, mark pixel, live counts and game_over.
module mark_score_ctrl #(
    parameter int          MAX_MARKS   = 8,
    parameter int          MARK_W      = 4,
    parameter int          MARK_H      = 20,
    parameter int          PITCH_LOG2  = 3,
    parameter int          P1_X0       = 16,
    parameter int          P2_X0       = 560,
    parameter int          MARKS_Y0    = 8,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    mark_score_ctrl_if.slave  bus
);

    localparam logic [3:0] LP_MAX      = 4'(MAX_MARKS);
    localparam logic [9:0] LP_P1_X0    = 10'(P1_X0);
    localparam logic [9:0] LP_P2_X0    = 10'(P2_X0);
    localparam logic [9:0] LP_Y0       = 10'(MARKS_Y0);
    localparam logic [9:0] LP_Y1       = 10'(MARKS_Y0 + MARK_H);
    localparam logic [9:0] LP_MW       = 10'(MARK_W);
    localparam logic [9:0] LP_OFF_MASK = 10'((1 << PITCH_LOG2) - 1);
    localparam logic [4:0] LP_Y0_5     = 5'(MARKS_Y0);

    logic [3:0] r_p1, r_p2;
    logic [3:0] r_disp1, r_disp2;
    logic       r_game_over;
    logic       r_hit_d1;

    // ---------------- counters ----------------
    logic       w_p1_inc, w_p2_inc;
    logic [3:0] w_p1_nxt, w_p2_nxt;

    assign w_p1_inc = bus.p1_point & ~r_game_over & (r_p1 != LP_MAX);
    assign w_p2_inc = bus.p2_point & ~r_game_over & (r_p2 != LP_MAX);
    assign w_p1_nxt = r_p1 + {3'd0, w_p1_inc};
    assign w_p2_nxt = r_p2 + {3'd0, w_p2_inc};

    // ---------------- stage 0: slot decode ----------------
    logic       w_in_band;
    logic       w_ge1, w_ge2;
    logic [9:0] w_dx1, w_dx2;
    logic [9:0] w_idx1, w_idx2;
    logic [9:0] w_off1, w_off2;
    logic       w_hit1, w_hit2, w_hit_any;
    logic [4:0] w_row;

    assign w_in_band = (bus.pixel_y >= LP_Y0) && (bus.pixel_y < LP_Y1);

    // The >= compare gates the subtract result, so a wrapped dx left of a
    // player's first slot can never produce a hit.
    assign w_ge1  = bus.pixel_x >= LP_P1_X0;
    assign w_ge2  = bus.pixel_x >= LP_P2_X0;
    assign w_dx1  = bus.pixel_x - LP_P1_X0;
    assign w_dx2  = bus.pixel_x - LP_P2_X0;
    assign w_idx1 = w_dx1 >> PITCH_LOG2;
    assign w_idx2 = w_dx2 >> PITCH_LOG2;
    assign w_off1 = w_dx1 & LP_OFF_MASK;
    assign w_off2 = w_dx2 & LP_OFF_MASK;

    assign w_hit1 = w_in_band & w_ge1 & (w_idx1 < {6'd0, r_disp1}) & (w_off1 < LP_MW);
    assign w_hit2 = w_in_band & w_ge2 & (w_idx2 < {6'd0, r_disp2}) & (w_off2 < LP_MW);
    assign w_hit_any = w_hit1 | w_hit2;

    // Row offset modulo 32 only needs the low five bits of y.
    assign w_row = bus.pixel_y[4:0] - LP_Y0_5;

    always_comb begin
        bus.rom_row = 5'd0;
        bus.rom_col = 2'd0;
        if (w_hit1) begin
            bus.rom_row = w_row;
            bus.rom_col = w_off1[1:0];
        end else if (w_hit2) begin
            bus.rom_row = w_row;
            bus.rom_col = w_off2[1:0];
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1        <= 4'd0;
            r_p2        <= 4'd0;
            r_disp1     <= 4'd0;
            r_disp2     <= 4'd0;
            r_game_over <= 1'b0;
            r_hit_d1    <= 1'b0;
        end else begin
            r_hit_d1 <= w_hit_any & bus.video_on;

            if (bus.clear_scores) begin
                r_p1        <= 4'd0;
                r_p2        <= 4'd0;
                r_game_over <= 1'b0;
            end else begin
                r_p1        <= w_p1_nxt;
                r_p2        <= w_p2_nxt;
                r_game_over <= r_game_over | (w_p1_nxt == LP_MAX) | (w_p2_nxt == LP_MAX);
            end

            // Copies take the pre-update count so a point landing on the
            // frame boundary appears one frame later.
            if (bus.frame_tick) begin
                r_disp1 <= bus.clear_scores ? 4'd0 : r_p1;
                r_disp2 <= bus.clear_scores ? 4'd0 : r_p2;
            end
        end
    end

    // ---------------- output ----------------
    assign bus.mark_on   = r_hit_d1 & (bus.rom_data != TRANSPARENT);
    assign bus.mark_rgb  = bus.mark_on ? bus.rom_data : 12'h000;
    assign bus.p1_count  = r_p1;
    assign bus.p2_count  = r_p2;
    assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_mark_score_ctrl.sv
// Purpose: directed bench for mark_score_ctrl with an independent slot/score model and a pixel scoreboard.
// Latency: expects mark_on/mark_rgb one clock after the pixel is presented.
// Backpressure: none.
module tb_mark_score_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mark_score_ctrl_if bus ();

    mark_score_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Sprite ROM model: registered read; row 12 is fully transparent.
    function automatic logic [11:0] rom_fn(input logic [4:0] row, input logic [1:0] col);
        if (row == 5'd12) return 12'h000;
        return 12'hF11 ^ {3'b000, row, 2'b00, col};
    endfunction

    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_row, bus.rom_col);

    typedef struct {
        logic        on;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference state
    int m_p1, m_p2, m_d1, m_d2;
    logic m_go;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_d1 = 0; m_d2 = 0; m_go = 1'b0;
    endtask

    // Reference slot decode written as an explicit scan over the lit slots.
    task automatic model_pix(input int x, input int y, output logic hit,
                             output logic [4:0] row, output logic [1:0] col);
        hit = 1'b0; row = 5'd0; col = 2'd0;
        if (y >= 8 && y < 28) begin
            for (int k = 0; k < m_d1; k++)
                if (!hit && x >= 16 + 8*k && x < 20 + 8*k) begin
                    hit = 1'b1; row = 5'(y - 8); col = 2'(x - 16 - 8*k);
                end
            for (int k = 0; k < m_d2; k++)
                if (!hit && x >= 560 + 8*k && x < 564 + 8*k) begin
                    hit = 1'b1; row = 5'(y - 8); col = 2'(x - 560 - 8*k);
                end
        end
    endtask

    task automatic pulse(input logic a, input logic b, input logic c, input logic f);
        bus.p1_point = a; bus.p2_point = b; bus.clear_scores = c; bus.frame_tick = f;
        @(posedge clk); #1;
        bus.p1_point = 0; bus.p2_point = 0; bus.clear_scores = 0; bus.frame_tick = 0;
        if (f) begin
            m_d1 = c ? 0 : m_p1;
            m_d2 = c ? 0 : m_p2;
        end
        if (c) begin
            m_p1 = 0; m_p2 = 0; m_go = 1'b0;
        end else begin
            if (!m_go) begin
                if (a && m_p1 < 8) m_p1++;
                if (b && m_p2 < 8) m_p2++;
            end
            if (m_p1 == 8 || m_p2 == 8) m_go = 1'b1;
        end
        chk("p1_count", 16'(bus.p1_count), 16'(m_p1));
        chk("p2_count", 16'(bus.p2_count), 16'(m_p2));
        chk("game_over", 16'(bus.game_over), 16'(m_go));
    endtask

    task automatic pix(input int x, input int y, input logic vid);
        logic       hit;
        logic [4:0] row;
        logic [1:0] col;
        logic [11:0] c;
        exp_t e;
        bus.pixel_x = 10'(x); bus.pixel_y = 10'(y); bus.video_on = vid;
        #1;
        model_pix(x, y, hit, row, col);
        chk("rom_row", 16'(bus.rom_row), 16'(row));
        chk("rom_col", 16'(bus.rom_col), 16'(col));
        c = rom_fn(row, col);
        e.on  = hit & vid & (c != 12'h000);
        e.rgb = e.on ? c : 12'h000;
        q.push_back(e);
        @(posedge clk); #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            e = q.pop_front();
            chk("mark_on", 16'(bus.mark_on), 16'(e.on));
            chk("mark_rgb", 16'(bus.mark_rgb), 16'(e.rgb));
        end
    endtask

    initial begin
        bus.pixel_x = 0; bus.pixel_y = 0; bus.video_on = 0;
        bus.frame_tick = 0; bus.p1_point = 0; bus.p2_point = 0; bus.clear_scores = 0;
        model_reset();

        // Power-on reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mark_on", 16'(bus.mark_on), 16'd0);
        chk("rst_p1", 16'(bus.p1_count), 16'd0);
        chk("rst_p2", 16'(bus.p2_count), 16'd0);
        chk("rst_go", 16'(bus.game_over), 16'd0);
        reset = 1'b0;

        // 1: build disp1=3, then reset mid-line on a lit pixel
        pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        pix(16, 8, 1);
        pix(33, 8, 1);
        bus.pixel_x = 10'd16; bus.pixel_y = 10'd8; bus.video_on = 1;
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        chk("midrst_mark_on", 16'(bus.mark_on), 16'd0);
        chk("midrst_rgb", 16'(bus.mark_rgb), 16'd0);
        chk("midrst_p1", 16'(bus.p1_count), 16'd0);
        chk("midrst_go", 16'(bus.game_over), 16'd0);
        reset = 1'b0;
        pix(16, 8, 1);

        // 2: one point, frame tick, scan slot 0, gap, slot 1
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        pix(16, 8, 1);
        pix(19, 8, 1);
        pix(20, 8, 1);
        pix(24, 8, 1);
        pix(15, 8, 1);
        pix(0, 8, 1);

        // 3: mid-frame point stays hidden until frame tick
        pulse(1, 0, 0, 0);
        pix(24, 8, 1);
        pulse(0, 0, 0, 1);
        pix(24, 8, 1);
        pix(27, 9, 1);

        // 4: transparent row, band edges, video blanking
        pix(16, 20, 1);
        pix(16, 27, 1);
        pix(16, 28, 1);
        pix(16, 7, 1);
        pix(16, 8, 0);

        // 5: player 2 runs to saturation; clear beats a simultaneous point
        for (int i = 0; i < 10; i++) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 1, 0);

        // 6: simultaneous points on a frame tick, then next tick shows them
        pulse(1, 1, 0, 1);
        pix(560, 10, 1);
        pix(16, 8, 1);
        pulse(0, 0, 0, 1);
        pix(560, 10, 1);
        pix(562, 10, 1);
        pix(16, 8, 1);
        // frame tick with clear loads zero copies
        pulse(0, 0, 1, 1);
        pix(560, 10, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
